ram_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the shared 32x8 single-port RAM (ramlpm: address, clock, data, wren, q).
- Two requesters issue read or write commands over a req/gnt handshake. The block grants round-robin, drives the RAM pins from registers, waits out the RAM read latency, and returns read data with a one-cycle valid pulse.
- Sits between board-level sources (switch-driven user port, auto fill/scan engine) and the RAM instance in the top level.

---
 rtl/ram_ctrl_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared constants and FSM state type for the RAM arbiter/sequencer.
package ram_ctrl_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared single-port RAM.
// RAM pins are driven from registers; read data returns with a one-cycle valid pulse.
module ram_arbiter #(
    parameter int unsigned ADDR_W   = ram_ctrl_pkg::ADDR_W,
    parameter int unsigned DATA_W   = ram_ctrl_pkg::DATA_W,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);
    import ram_ctrl_pkg::*;

    localparam int unsigned CNT_W = 2;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;
    logic              owner_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              ram_wren_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] ram_data_q;
    logic [ADDR_W-1:0] ram_address_q;

    logic              winner;
    logic              pick_valid;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    rr_arbiter2 u_rr (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (winner),
        .valid  (pick_valid)
    );

    always_comb begin
        sel_we_d    = winner ? we1    : we0;
        sel_addr_d  = winner ? addr1  : addr0;
        sel_wdata_d = winner ? wdata1 : wdata0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            ram_wren_q    <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            ram_data_q    <= '0;
            ram_address_q <= '0;
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q       <= winner;
                        last_q        <= winner;
                        ram_address_q <= sel_addr_d;
                        ram_data_q    <= sel_wdata_d;
                        ram_wren_q    <= sel_we_d;
                        gnt0_q        <= ~winner;
                        gnt1_q        <= winner;
                        state_q       <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_wren_q <= 1'b0;
                    cnt_q      <= CNT_W'(READ_LAT);
                    state_q    <= ram_wren_q ? IDLE : WAIT;
                end
                WAIT: begin
                    // WAIT spans READ_LAT+1 cycles so q is sampled a full cycle after it settles.
                    if (cnt_q == '0) begin
                        if (owner_q) begin
                            rdata1_q  <= ram_q;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= ram_q;
                            rvalid0_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model for READ_LAT=1, directed READ_LAT=2 checks.
module tb_ram_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int RL_A = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0]    a_req, a_we, a_gnt, a_rv;
    logic [AW-1:0] a_addr [2];
    logic [DW-1:0] a_wd [2];
    logic [DW-1:0] a_rd [2];
    logic [AW-1:0] a_ram_address;
    logic [DW-1:0] a_ram_data, a_ram_q;
    logic          a_ram_wren, a_busy;

    logic [1:0]    b_req, b_we, b_gnt, b_rv;
    logic [AW-1:0] b_addr [2];
    logic [DW-1:0] b_wd [2];
    logic [DW-1:0] b_rd [2];
    logic [AW-1:0] b_ram_address;
    logic [DW-1:0] b_ram_data, b_ram_q, b_q1;
    logic          b_ram_wren, b_busy;

    ram_arbiter #(.READ_LAT(1)) u_dut_a (
        .CLOCK_50(clk), .reset(rst),
        .req0(a_req[0]), .we0(a_we[0]), .addr0(a_addr[0]), .wdata0(a_wd[0]),
        .gnt0(a_gnt[0]), .rvalid0(a_rv[0]), .rdata0(a_rd[0]),
        .req1(a_req[1]), .we1(a_we[1]), .addr1(a_addr[1]), .wdata1(a_wd[1]),
        .gnt1(a_gnt[1]), .rvalid1(a_rv[1]), .rdata1(a_rd[1]),
        .ram_address(a_ram_address), .ram_data(a_ram_data), .ram_wren(a_ram_wren),
        .ram_q(a_ram_q), .busy(a_busy)
    );

    ram_arbiter #(.READ_LAT(2)) u_dut_b (
        .CLOCK_50(clk), .reset(rst),
        .req0(b_req[0]), .we0(b_we[0]), .addr0(b_addr[0]), .wdata0(b_wd[0]),
        .gnt0(b_gnt[0]), .rvalid0(b_rv[0]), .rdata0(b_rd[0]),
        .req1(b_req[1]), .we1(b_we[1]), .addr1(b_addr[1]), .wdata1(b_wd[1]),
        .gnt1(b_gnt[1]), .rvalid1(b_rv[1]), .rdata1(b_rd[1]),
        .ram_address(b_ram_address), .ram_data(b_ram_data), .ram_wren(b_ram_wren),
        .ram_q(b_ram_q), .busy(b_busy)
    );

    // RAM models: A has one cycle of read latency, B two.
    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];
    always @(posedge clk) begin
        if (a_ram_wren) mem_a[a_ram_address] <= a_ram_data;
        a_ram_q <= mem_a[a_ram_address];
        if (b_ram_wren) mem_b[b_ram_address] <= b_ram_data;
        b_q1    <= mem_b[b_ram_address];
        b_ram_q <= b_q1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction-level reference model for DUT A.
    int            m_free, m_rv_edge, m_wr_edge, m_rv_port;
    logic          m_last;
    logic [AW-1:0] m_rv_addr, m_wr_addr;
    logic [DW-1:0] m_wr_data;
    logic [DW-1:0] shadow [32];
    logic [DW-1:0] m_rd [2];

    task automatic step_a();
        int e, w;
        logic [1:0] eg, erv;
        logic ewren, ebusy;
        e = cyc + 1;
        eg = '0;
        erv = '0;
        ewren = 1'b0;
        if (e == m_wr_edge) shadow[m_wr_addr] = m_wr_data;
        if (e >= m_free && a_req != 2'b00) begin
            if (a_req == 2'b11) w = m_last ? 0 : 1;
            else w = a_req[1] ? 1 : 0;
            m_last = w[0];
            eg[w] = 1'b1;
            if (a_we[w]) begin
                m_wr_edge = e + 1;
                m_wr_addr = a_addr[w];
                m_wr_data = a_wd[w];
                m_free = e + 2;
                ewren = 1'b1;
            end else begin
                m_rv_edge = e + 2 + RL_A;
                m_rv_port = w;
                m_rv_addr = a_addr[w];
                m_free = e + 3 + RL_A;
            end
        end
        if (e == m_rv_edge) begin
            erv[m_rv_port] = 1'b1;
            m_rd[m_rv_port] = shadow[m_rv_addr];
        end
        ebusy = (e < m_free - 1);
        @(posedge clk);
        #1;
        cyc = e;
        checks++;
        if (a_gnt !== eg) begin
            errors++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, a_gnt, eg);
        end
        checks++;
        if (a_rv !== erv) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, a_rv, erv);
        end
        checks++;
        if (a_rd[0] !== m_rd[0] || a_rd[1] !== m_rd[1]) begin
            errors++;
            $display("FAIL rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, a_rd[0], a_rd[1], m_rd[0], m_rd[1]);
        end
        checks++;
        if (a_busy !== ebusy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, a_busy, ebusy);
        end
        checks++;
        if (a_ram_wren !== ewren) begin
            errors++;
            $display("FAIL ram_wren cyc=%0d got=%b exp=%b", cyc, a_ram_wren, ewren);
        end
    endtask

    task automatic do_reset();
        a_req = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_gnt, a_rv, a_rd[0], a_rd[1], a_ram_address, a_ram_data, a_ram_wren, a_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b rv=%b rd=%h/%h addr=%h data=%h wren=%b busy=%b exp all 0",
                     a_gnt, a_rv, a_rd[0], a_rd[1], a_ram_address, a_ram_data, a_ram_wren, a_busy);
        end
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        m_last = 1'b1;
        m_free = 0;
        m_rv_edge = -1;
        m_wr_edge = -1;
        m_rd[0] = '0;
        m_rd[1] = '0;
    endtask

    task automatic a_cmd(input int p, input logic we, input logic [AW-1:0] ad,
                         input logic [DW-1:0] d, output int cap);
        int n;
        a_req[p] = 1'b1;
        a_we[p] = we;
        a_addr[p] = ad;
        a_wd[p] = d;
        n = 0;
        do begin step_a(); n++; end while (!a_gnt[p] && n < 20);
        checks++;
        if (!a_gnt[p]) begin
            errors++;
            $display("FAIL gnt_timeout port=%0d got=0 exp=1", p);
        end
        cap = cyc;
        a_req[p] = 1'b0;
        if (!we) begin
            n = 0;
            do begin step_a(); n++; end while (!a_rv[p] && n < 20);
            checks++;
            if (!a_rv[p]) begin
                errors++;
                $display("FAIL rvalid_timeout port=%0d got=0 exp=1", p);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({b_gnt, b_rv, b_rd[0], b_rd[1], b_ram_address, b_ram_data, b_ram_wren, b_busy} !== '0) begin
            errors++;
            $display("FAIL reset_b busy=%b gnt=%b exp 0", b_busy, b_gnt);
        end
    endtask

    task automatic test_write_read();
        int cap;
        a_cmd(0, 1'b1, 5'd5, 8'hA5, cap);
        a_cmd(0, 1'b0, 5'd5, 8'h00, cap);
        checks++;
        if (cyc - cap != 3) begin
            errors++;
            $display("FAIL read_latency got=%0d exp=3", cyc - cap);
        end
        checks++;
        if (a_rd[0] !== 8'hA5) begin
            errors++;
            $display("FAIL read_data got=%h exp=a5", a_rd[0]);
        end
    endtask

    task automatic test_isolation();
        int cap;
        a_cmd(1, 1'b1, 5'd31, 8'h3C, cap);
        a_cmd(0, 1'b0, 5'd31, 8'h00, cap);
        checks++;
        if (a_rd[0] !== 8'h3C) begin
            errors++;
            $display("FAIL iso_rdata0 got=%h exp=3c", a_rd[0]);
        end
        checks++;
        if (a_rd[1] !== 8'h00) begin
            errors++;
            $display("FAIL iso_rdata1 got=%h exp=00", a_rd[1]);
        end
    endtask

    task automatic test_tie();
        int seq[$];
        int n, got;
        do_reset();
        a_req = 2'b11;
        a_we = 2'b00;
        a_addr[0] = AW'($urandom);
        a_addr[1] = AW'($urandom);
        n = 0;
        while (seq.size() < 4 && n < 60) begin
            step_a();
            n++;
            if (a_gnt[0]) seq.push_back(0);
            if (a_gnt[1]) seq.push_back(1);
        end
        a_req = 2'b00;
        repeat (6) step_a();
        got = 0;
        foreach (seq[k]) got = got * 10 + seq[k];
        checks++;
        if (seq.size() != 4 || got != 101) begin
            errors++;
            $display("FAIL tie_order got=%0d (n=%0d) exp=0101", got, seq.size());
        end
    endtask

    task automatic test_back_to_back();
        int grants;
        grants = 0;
        a_req = 2'b10;
        a_we[1] = 1'b1;
        a_addr[1] = 5'd20;
        a_wd[1] = 8'h40;
        for (int i = 0; i < 8; i++) begin
            step_a();
            if (a_gnt[1]) begin
                grants++;
                a_wd[1] = a_wd[1] + 8'h01;
            end
        end
        a_req = 2'b00;
        repeat (2) step_a();
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL back_to_back grants got=%0d exp=4", grants);
        end
    endtask

    task automatic test_reset_wait();
        int n;
        a_req = 2'b01;
        a_we[0] = 1'b0;
        a_addr[0] = 5'd5;
        n = 0;
        do begin step_a(); n++; end while (!a_gnt[0] && n < 20);
        a_req = 2'b00;
        step_a();
        do_reset();
        repeat (4) step_a();
        a_req = 2'b11;
        a_we = 2'b00;
        n = 0;
        do begin step_a(); n++; end while (a_gnt == 2'b00 && n < 5);
        checks++;
        if (a_gnt !== 2'b01) begin
            errors++;
            $display("FAIL tie_after_reset got=%b exp=01", a_gnt);
        end
        a_req = 2'b00;
        repeat (6) step_a();
    endtask

    task automatic test_reset_write();
        int n, cap;
        a_req = 2'b01;
        a_we[0] = 1'b1;
        a_addr[0] = 5'd7;
        a_wd[0] = 8'hFF;
        n = 0;
        do begin step_a(); n++; end while (!a_gnt[0] && n < 20);
        do_reset();
        a_cmd(0, 1'b0, 5'd7, 8'h00, cap);
        checks++;
        if (a_rd[0] !== 8'h00) begin
            errors++;
            $display("FAIL aborted_write got=%h exp=00", a_rd[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (a_gnt[p]) a_req[p] = 1'b0;
                if (!a_req[p] && $urandom_range(0, 2) == 0) begin
                    a_req[p] = 1'b1;
                    a_we[p] = 1'($urandom_range(0, 1));
                    a_addr[p] = AW'($urandom);
                    a_wd[p] = DW'($urandom);
                end
            end
            step_a();
        end
        a_req = 2'b00;
        repeat (8) step_a();
    endtask

    task automatic test_lat2();
        int cap, rv, nb, n;
        b_req = 2'b01;
        b_we[0] = 1'b1;
        b_addr[0] = 5'd0;
        b_wd[0] = 8'h11;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!b_gnt[0] && n < 20);
        checks++;
        if (!b_gnt[0]) begin
            errors++;
            $display("FAIL lat2_write_gnt got=0 exp=1");
        end
        b_req = 2'b00;
        @(posedge clk); #1;
        b_req = 2'b01;
        b_we[0] = 1'b0;
        cap = -1;
        rv = -1;
        nb = 0;
        for (int i = 1; i <= 20 && rv < 0; i++) begin
            @(posedge clk); #1;
            if (b_gnt[0] && cap < 0) begin
                cap = i;
                b_req = 2'b00;
            end
            if (cap >= 0 && b_busy) nb++;
            if (b_rv[0]) rv = i;
        end
        checks++;
        if (rv < 0 || cap < 0 || rv - cap != 4) begin
            errors++;
            $display("FAIL lat2_latency got=%0d exp=4", rv - cap);
        end
        checks++;
        if (b_rd[0] !== 8'h11) begin
            errors++;
            $display("FAIL lat2_rdata got=%h exp=11", b_rd[0]);
        end
        checks++;
        if (nb != 4) begin
            errors++;
            $display("FAIL lat2_busy_cycles got=%0d exp=4", nb);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_req = '0; a_we = '0;
        b_req = '0; b_we = '0;
        for (int p = 0; p < 2; p++) begin
            a_addr[p] = '0; a_wd[p] = '0;
            b_addr[p] = '0; b_wd[p] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            shadow[i] = '0;
        end
        a_ram_q = '0;
        b_ram_q = '0;
        b_q1 = '0;
        test_reset();
        test_write_read();
        test_isolation();
        test_tie();
        test_back_to_back();
        test_reset_wait();
        test_reset_write();
        test_random();
        test_lat2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
